// File: rtl/load_unit_fsm.sv
// load_unit_fsm: sequential load unit between the execute stage and an
// Avalon-style read bus. Takes one load at a time, issues a word-aligned
// read with lane enables, then returns the extracted, extended or merged
// value as a one-cycle response carrying an error code.
module load_unit_fsm #(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int TIMEOUT    = 255,
   parameter bit EN_UNALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_rt_old,
   input  logic [4:0]  req_tag,
   output logic [31:0] address,
   output logic        read,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_tag,
   output logic [1:0]  rsp_err,
   output logic        busy
);

   localparam logic [2:0] F_LB  = 3'b000;
   localparam logic [2:0] F_LH  = 3'b001;
   localparam logic [2:0] F_LWL = 3'b010;
   localparam logic [2:0] F_LW  = 3'b011;
   localparam logic [2:0] F_LBU = 3'b100;
   localparam logic [2:0] F_LHU = 3'b101;
   localparam logic [2:0] F_LWR = 3'b110;
   localparam logic [2:0] F_ILL = 3'b111;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;

   // Counter is one bit wider in the compare so TIMEOUT itself is reachable.
   localparam int             CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] address_q, address_d;
   logic        read_q, read_d;
   logic [3:0]  be_q, be_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [4:0]  rsp_tag_q, rsp_tag_d;
   logic [1:0]  rsp_err_q, rsp_err_d;

   // Request fields captured on accept and used when the read data returns.
   logic [2:0]  funct_q;
   logic [1:0]  k_q;
   logic [31:0] rt_q;
   logic [4:0]  tag_q;
   logic        lat_en;

   // Requests the unit refuses without touching the bus.
   function automatic logic is_illegal(input logic [2:0] f, input logic [1:0] k);
      logic bad;
      bad = 1'b0;
      case (f)
         F_LW:         bad = (k != 2'b00);
         F_LH, F_LHU:  bad = k[0];
         F_LWL, F_LWR: bad = !EN_UNALIGN;
         F_ILL:        bad = 1'b1;
         default:      bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Lane enables for the addressed byte, halfword or full word.
   function automatic logic [3:0] lane_mask(input logic [2:0] f, input logic [1:0] k);
      logic [3:0] m;
      case (f)
         F_LB, F_LBU: m = 4'b0001 << k;
         F_LH, F_LHU: m = k[1] ? 4'b1100 : 4'b0011;
         default:     m = 4'b1111;
      endcase
      return m;
   endfunction

   // Extract, endian-convert, extend or merge the returned bus word.
   function automatic logic [31:0] load_value(input logic [2:0]  f,
                                              input logic [1:0]  k,
                                              input logic [31:0] rt,
                                              input logic [31:0] rdata);
      logic [31:0] word;
      logic [31:0] sh_b0;
      logic [31:0] sh_b1;
      logic [7:0]  bk;
      logic [7:0]  bk1;
      logic [15:0] half;
      logic [4:0]  sh_l;
      logic [4:0]  sh_r;
      logic [1:0]  k1;
      logic [31:0] res;
      word  = BIG_ENDIAN ? {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]} : rdata;
      k1    = k + 2'd1;
      sh_b0 = rdata >> {k, 3'b000};
      sh_b1 = rdata >> {k1, 3'b000};
      bk    = sh_b0[7:0];
      bk1   = sh_b1[7:0];
      half  = BIG_ENDIAN ? {bk, bk1} : {bk1, bk};
      // LWL/LWR reduce to shifts of the register-ordered word in either endianness.
      sh_l  = {k, 3'b000};
      sh_r  = {~k, 3'b000};
      case (f)
         F_LB:    res = {{24{bk[7]}}, bk};
         F_LBU:   res = {24'h000000, bk};
         F_LH:    res = {{16{half[15]}}, half};
         F_LHU:   res = {16'h0000, half};
         F_LW:    res = word;
         F_LWL:   res = (word << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
         F_LWR:   res = (word >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

   // Next-state and registered-output computation for the load sequence.
   always_comb begin
      state_d     = state_q;
      address_d   = address_q;
      read_d      = read_q;
      be_d        = be_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_err_d   = rsp_err_q;
      lat_en      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               lat_en = 1'b1;
               if (is_illegal(req_funct, req_addr[1:0])) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 32'h0000_0000;
                  rsp_err_d   = ERR_ALIGN;
                  rsp_tag_d   = req_tag;
               end else begin
                  state_d   = S_READ;
                  read_d    = 1'b1;
                  address_d = {req_addr[31:2], 2'b00};
                  be_d      = lane_mask(req_funct, req_addr[1:0]);
                  cnt_d     = '0;
               end
            end
         end
         S_READ: begin
            if (!waitrequest) begin
               state_d     = S_RESP;
               read_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = load_value(funct_q, k_q, rt_q, readdata);
               rsp_err_d   = ERR_OK;
               rsp_tag_d   = tag_q;
            end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
               state_d     = S_RESP;
               read_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = 32'h0000_0000;
               rsp_err_d   = ERR_TMO;
               rsp_tag_d   = tag_q;
            end else begin
               cnt_d = cnt_inc[CNT_W-1:0];
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            read_d  = 1'b0;
         end
      endcase
   end

   // State, bus strobes and response registers; reset clears any transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         address_q   <= 32'h0000_0000;
         read_q      <= 1'b0;
         be_q        <= 4'b0000;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0000_0000;
         rsp_tag_q   <= 5'd0;
         rsp_err_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         address_q   <= address_d;
         read_q      <= read_d;
         be_q        <= be_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Capture the accepted request's fields; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (lat_en) begin
         funct_q <= req_funct;
         k_q     <= req_addr[1:0];
         rt_q    <= req_rt_old;
         tag_q   <= req_tag;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign address    = address_q;
   assign read       = read_q;
   assign byteenable = be_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_load_unit_fsm.sv
// tb_load_unit_fsm: directed checks of load_unit_fsm with a big-endian and a
// little-endian instance sharing the same stimulus (both with TIMEOUT=4).
module tb_load_unit_fsm;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [2:0]  req_funct;
   logic [31:0] req_addr;
   logic [31:0] req_rt_old;
   logic [4:0]  req_tag;
   logic        waitrequest;
   logic [31:0] readdata;

   logic        req_ready, read, rsp_valid, busy;
   logic [31:0] address, rsp_data;
   logic [3:0]  byteenable;
   logic [4:0]  rsp_tag;
   logic [1:0]  rsp_err;

   logic        req_ready_le, read_le, rsp_valid_le, busy_le;
   logic [31:0] address_le, rsp_data_le;
   logic [3:0]  byteenable_le;
   logic [4:0]  rsp_tag_le;
   logic [1:0]  rsp_err_le;

   int n_tests = 0;
   int n_fail  = 0;

   load_unit_fsm #(.BIG_ENDIAN(1'b1), .TIMEOUT(4), .EN_UNALIGN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
      .req_addr(req_addr), .req_rt_old(req_rt_old), .req_tag(req_tag),
      .address(address), .read(read), .byteenable(byteenable),
      .waitrequest(waitrequest), .readdata(readdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_err(rsp_err), .busy(busy)
   );

   load_unit_fsm #(.BIG_ENDIAN(1'b0), .TIMEOUT(4), .EN_UNALIGN(1'b1)) dut_le (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready_le), .req_funct(req_funct),
      .req_addr(req_addr), .req_rt_old(req_rt_old), .req_tag(req_tag),
      .address(address_le), .read(read_le), .byteenable(byteenable_le),
      .waitrequest(waitrequest), .readdata(readdata),
      .rsp_valid(rsp_valid_le), .rsp_data(rsp_data_le), .rsp_tag(rsp_tag_le),
      .rsp_err(rsp_err_le), .busy(busy_le)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge (edge 0); returns 1 time unit into cycle 1.
   task automatic issue(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] rt, input logic [4:0] t);
      req_funct  = f;
      req_addr   = a;
      req_rt_old = rt;
      req_tag    = t;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_funct   = 3'b000;
      req_addr    = 32'h0;
      req_rt_old  = 32'h0;
      req_tag     = 5'd0;
      waitrequest = 1'b0;
      readdata    = 32'h0;

      #2;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_read", {31'b0, read}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_byteenable", {28'b0, byteenable}, 32'h0);
      chk("rst_address", address, 32'h0);
      chk("rst_rsp_err", {30'b0, rsp_err}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // LB at offset 3, no wait states
      readdata = 32'h8011_2233;
      issue(3'b000, 32'h0000_1003, 32'h0, 5'd5);
      @(negedge clk);
      chk("lb_c1_read", {31'b0, read}, 32'd1);
      chk("lb_c1_be", {28'b0, byteenable}, 32'h8);
      chk("lb_c1_addr", address, 32'h0000_1000);
      chk("lb_c1_ready", {31'b0, req_ready}, 32'd0);
      chk("lb_c1_busy", {31'b0, busy}, 32'd1);
      chk("lb_c1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lb_c2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("lb_c2_data", rsp_data, 32'hFFFF_FF80);
      chk("lb_c2_err", {30'b0, rsp_err}, 32'h0);
      chk("lb_c2_tag", {27'b0, rsp_tag}, 32'd5);
      chk("lb_c2_read", {31'b0, read}, 32'd0);
      chk("lb_c2_ready", {31'b0, req_ready}, 32'd0);
      chk("lb_c2_data_le", rsp_data_le, 32'hFFFF_FF80);
      @(negedge clk);
      chk("lb_c3_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("lb_c3_ready", {31'b0, req_ready}, 32'd1);

      // LHU at offset 2 with three wait cycles
      readdata    = 32'hA1B2_C3D4;
      waitrequest = 1'b1;
      issue(3'b101, 32'h0000_2002, 32'h0, 5'd7);
      @(negedge clk);
      chk("lhu_c1_be", {28'b0, byteenable}, 32'hC);
      chk("lhu_c1_read", {31'b0, read}, 32'd1);
      @(negedge clk);
      chk("lhu_c2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lhu_c3_read", {31'b0, read}, 32'd1);
      chk("lhu_c3_be_hold", {28'b0, byteenable}, 32'hC);
      chk("lhu_c3_addr_hold", address, 32'h0000_2000);
      @(posedge clk);
      #1 waitrequest = 1'b0;
      @(negedge clk);
      chk("lhu_c4_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("lhu_c4_read", {31'b0, read}, 32'd1);
      @(negedge clk);
      chk("lhu_c5_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("lhu_c5_data", rsp_data, 32'h0000_B2A1);
      chk("lhu_c5_data_le", rsp_data_le, 32'h0000_A1B2);
      chk("lhu_c5_tag", {27'b0, rsp_tag}, 32'd7);
      @(negedge clk);

      // LWL offset 1 and LWR offset 0 merging with rt_old
      readdata = 32'hDDCC_BBAA;
      issue(3'b010, 32'h0000_3001, 32'h1122_3344, 5'd9);
      @(negedge clk);
      chk("lwl_c1_be", {28'b0, byteenable}, 32'hF);
      @(negedge clk);
      chk("lwl_c2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("lwl_c2_data", rsp_data, 32'hBBCC_DD44);
      chk("lwl_c2_data_le", rsp_data_le, 32'hCCBB_AA44);
      @(negedge clk);
      issue(3'b110, 32'h0000_3000, 32'h1122_3344, 5'd10);
      @(negedge clk);
      @(negedge clk);
      chk("lwr_c2_data", rsp_data, 32'h1122_33AA);
      chk("lwr_c2_data_le", rsp_data_le, 32'h1122_33DD);
      chk("lwr_c2_tag", {27'b0, rsp_tag}, 32'd10);
      @(negedge clk);

      // LW word read, both byte orders
      readdata = 32'h1234_5678;
      issue(3'b011, 32'h0000_4004, 32'h0, 5'd11);
      @(negedge clk);
      @(negedge clk);
      chk("lw_c2_data", rsp_data, 32'h7856_3412);
      chk("lw_c2_data_le", rsp_data_le, 32'h1234_5678);
      @(negedge clk);

      // Misaligned LW: no bus read, error response in cycle 1
      readdata = 32'hFFFF_FFFF;
      issue(3'b011, 32'h0000_4002, 32'h0, 5'd3);
      @(negedge clk);
      chk("mis_c1_read", {31'b0, read}, 32'd0);
      chk("mis_c1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("mis_c1_err", {30'b0, rsp_err}, 32'h1);
      chk("mis_c1_data", rsp_data, 32'h0);
      chk("mis_c1_tag", {27'b0, rsp_tag}, 32'd3);
      @(negedge clk);
      chk("mis_c2_read", {31'b0, read}, 32'd0);
      chk("mis_c2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mis_c2_ready", {31'b0, req_ready}, 32'd1);

      // Odd-address LH and the illegal funct code
      issue(3'b001, 32'h0000_5001, 32'h0, 5'd1);
      @(negedge clk);
      chk("lh_odd_err", {30'b0, rsp_err}, 32'h1);
      chk("lh_odd_read", {31'b0, read}, 32'd0);
      @(negedge clk);
      issue(3'b111, 32'h0000_5000, 32'h0, 5'd2);
      @(negedge clk);
      chk("ill_err", {30'b0, rsp_err}, 32'h1);
      chk("ill_tag", {27'b0, rsp_tag}, 32'd2);
      chk("ill_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      @(negedge clk);

      // Timeout: waitrequest stuck high for four stall cycles
      waitrequest = 1'b1;
      issue(3'b011, 32'h0000_6000, 32'h0, 5'd12);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("tmo_c4_read", {31'b0, read}, 32'd1);
      chk("tmo_c4_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("tmo_c5_read", {31'b0, read}, 32'd0);
      chk("tmo_c5_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("tmo_c5_err", {30'b0, rsp_err}, 32'h2);
      chk("tmo_c5_data", rsp_data, 32'h0);
      chk("tmo_c5_tag", {27'b0, rsp_tag}, 32'd12);
      @(negedge clk);
      chk("tmo_c6_ready", {31'b0, req_ready}, 32'd1);
      chk("tmo_c6_busy", {31'b0, busy}, 32'd0);

      // Reset during a stalled read, then a clean request
      issue(3'b000, 32'h0000_7000, 32'h0, 5'd2);
      @(negedge clk);
      chk("rstm_c1_read", {31'b0, read}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_read_drop", {31'b0, read}, 32'd0);
      chk("rstm_busy", {31'b0, busy}, 32'd0);
      chk("rstm_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rstm_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("rstm_no_read", {31'b0, read}, 32'd0);
      waitrequest = 1'b0;
      readdata    = 32'h1234_5678;
      issue(3'b100, 32'h0000_7002, 32'h0, 5'd4);
      @(negedge clk);
      chk("post_c1_be", {28'b0, byteenable}, 32'h4);
      @(negedge clk);
      chk("post_c2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("post_c2_data", rsp_data, 32'h0000_0034);
      chk("post_c2_tag", {27'b0, rsp_tag}, 32'd4);
      chk("post_c2_err", {30'b0, rsp_err}, 32'h0);
      chk("post_c2_tag_le", {27'b0, rsp_tag_le}, 32'd4);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
